// File: rtl/gshare_branch_predictor.sv
// Gshare direction predictor with a direct-mapped BTB for the fetch stage.
// Trained and history-repaired from the EX-stage branch resolution interface.
module gshare_branch_predictor #(
    parameter int unsigned GHR_BITS = 4,
    parameter int unsigned BTB_BITS = 4,
    parameter int unsigned CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         fetch_pc,
    input  logic                fetch_valid,
    output logic [31:0]         predicted_pc,
    output logic                prediction_valid,
    output logic [GHR_BITS-1:0] ghr_out,
    input  logic                branch_resolved,
    input  logic                branch_taken,
    input  logic [31:0]         branch_addr,
    input  logic [31:0]         resolved_pc,
    input  logic [GHR_BITS-1:0] ghr_history,
    input  logic                pc_redirect,
    output logic [CNT_BITS-1:0] resolve_count,
    output logic [CNT_BITS-1:0] mispredict_count
);

    localparam int unsigned PHT_N = 1 << GHR_BITS;
    localparam int unsigned BTB_N = 1 << BTB_BITS;
    localparam int unsigned TAG_W = 30 - BTB_BITS;

    logic [1:0]          pht_q        [PHT_N];
    logic                btb_valid_q  [BTB_N];
    logic [TAG_W-1:0]    btb_tag_q    [BTB_N];
    logic [31:0]         btb_target_q [BTB_N];

    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic [CNT_BITS-1:0] resolve_cnt_q, resolve_cnt_d;
    logic [CNT_BITS-1:0] mispred_cnt_q, mispred_cnt_d;

    logic [GHR_BITS-1:0] lk_pht_idx;
    logic [BTB_BITS-1:0] lk_btb_idx;
    logic                btb_hit;
    logic                pred_taken;

    logic [GHR_BITS-1:0] upd_pht_idx;
    logic [BTB_BITS-1:0] upd_btb_idx;
    logic [1:0]          upd_old;
    logic [1:0]          upd_new;

    logic                unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[1:0], resolved_pc[1:0]};

    // Lookup reads registered state only, so same-cycle updates are not bypassed
    always_comb begin
        lk_pht_idx = fetch_pc[GHR_BITS+1:2] ^ ghr_q;
        lk_btb_idx = fetch_pc[BTB_BITS+1:2];
        btb_hit    = btb_valid_q[lk_btb_idx] &&
                     (btb_tag_q[lk_btb_idx] == fetch_pc[31:BTB_BITS+2]);
        pred_taken = btb_hit && pht_q[lk_pht_idx][1];
    end

    always_comb begin
        if (rst) begin
            prediction_valid = 1'b0;
            predicted_pc     = fetch_pc + 32'd4;
            ghr_out          = '0;
        end else begin
            prediction_valid = pred_taken;
            predicted_pc     = pred_taken ? btb_target_q[lk_btb_idx] : fetch_pc + 32'd4;
            ghr_out          = ghr_q;
        end
    end

    // Redirect repair overrides any speculative shift in the same cycle
    always_comb begin
        ghr_d = ghr_q;
        if (pc_redirect) begin
            if (branch_resolved) begin
                ghr_d = {ghr_history[GHR_BITS-2:0], branch_taken};
            end else begin
                ghr_d = ghr_history;
            end
        end else if (fetch_valid && btb_hit) begin
            ghr_d = {ghr_q[GHR_BITS-2:0], pred_taken};
        end
    end

    always_comb begin
        upd_pht_idx = resolved_pc[GHR_BITS+1:2] ^ ghr_history;
        upd_btb_idx = resolved_pc[BTB_BITS+1:2];
        upd_old     = pht_q[upd_pht_idx];
        upd_new     = upd_old;
        if (branch_taken) begin
            if (upd_old != 2'b11) upd_new = upd_old + 2'b01;
        end else begin
            if (upd_old != 2'b00) upd_new = upd_old - 2'b01;
        end
    end

    always_comb begin
        resolve_cnt_d = resolve_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (branch_resolved) resolve_cnt_d = resolve_cnt_q + CNT_BITS'(1);
        if (pc_redirect)     mispred_cnt_d = mispred_cnt_q + CNT_BITS'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < PHT_N; i++) begin
                pht_q[i] <= 2'b01;
            end
            for (int unsigned i = 0; i < BTB_N; i++) begin
                btb_valid_q[i]  <= 1'b0;
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= '0;
            end
            ghr_q         <= '0;
            resolve_cnt_q <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (branch_resolved) begin
                pht_q[upd_pht_idx] <= upd_new;
                if (branch_taken) begin
                    btb_valid_q[upd_btb_idx]  <= 1'b1;
                    btb_tag_q[upd_btb_idx]    <= resolved_pc[31:BTB_BITS+2];
                    btb_target_q[upd_btb_idx] <= branch_addr;
                end
            end
            ghr_q         <= ghr_d;
            resolve_cnt_q <= resolve_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign resolve_count    = resolve_cnt_q;
    assign mispredict_count = mispred_cnt_q;

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed self-checking bench for gshare_branch_predictor.
// Expected values are hand-derived from the PHT/BTB/GHR behaviour.
module tb_gshare_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic [31:0] predicted_pc;
    logic        prediction_valid;
    logic [3:0]  ghr_out;
    logic        branch_resolved;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] resolved_pc;
    logic [3:0]  ghr_history;
    logic        pc_redirect;
    logic [15:0] resolve_count;
    logic [15:0] mispredict_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gshare_branch_predictor #(
        .GHR_BITS(4),
        .BTB_BITS(4),
        .CNT_BITS(16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_pc         (fetch_pc),
        .fetch_valid      (fetch_valid),
        .predicted_pc     (predicted_pc),
        .prediction_valid (prediction_valid),
        .ghr_out          (ghr_out),
        .branch_resolved  (branch_resolved),
        .branch_taken     (branch_taken),
        .branch_addr      (branch_addr),
        .resolved_pc      (resolved_pc),
        .ghr_history      (ghr_history),
        .pc_redirect      (pc_redirect),
        .resolve_count    (resolve_count),
        .mispredict_count (mispredict_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic [3:0] hist);
        branch_resolved = 1'b1;
        branch_taken    = tk;
        resolved_pc     = pc;
        branch_addr     = tgt;
        ghr_history     = hist;
        step();
        branch_resolved = 1'b0;
        branch_taken    = 1'b0;
    endtask

    initial begin
        logic [3:0] shift_exp [3];
        shift_exp[0] = 4'h0;
        shift_exp[1] = 4'h1;
        shift_exp[2] = 4'h3;

        rst = 1'b1; fetch_pc = 32'h100; fetch_valid = 1'b0;
        branch_resolved = 1'b0; branch_taken = 1'b0; branch_addr = '0;
        resolved_pc = '0; ghr_history = '0; pc_redirect = 1'b0;

        // Reset
        step();
        check("rst_hold_pv", 32'(prediction_valid), 32'd0);
        check("rst_hold_ppc", predicted_pc, 32'h104);
        step();
        rst = 1'b0;
        #1;
        check("rst_pv", 32'(prediction_valid), 32'd0);
        check("rst_ppc", predicted_pc, 32'h104);
        check("rst_ghr", 32'(ghr_out), 32'd0);
        check("rst_rcnt", 32'(resolve_count), 32'd0);
        check("rst_mcnt", 32'(mispredict_count), 32'd0);

        // Training; lookup of the same entry in the update cycle sees old state
        fetch_pc = 32'h40;
        branch_resolved = 1'b1; branch_taken = 1'b1;
        resolved_pc = 32'h40; branch_addr = 32'h20; ghr_history = 4'h0;
        #1;
        check("nobypass_pv", 32'(prediction_valid), 32'd0);
        check("nobypass_ppc", predicted_pc, 32'h44);
        step();
        branch_resolved = 1'b0; branch_taken = 1'b0;
        #1;
        check("train_pv", 32'(prediction_valid), 32'd1);
        check("train_ppc", predicted_pc, 32'h20);
        check("train_rcnt", 32'(resolve_count), 32'd1);

        // Saturation: counter 2 -> 3 (saturates), then two not-taken
        for (int i = 0; i < 3; i++) resolve(32'h40, 1'b1, 32'h20, 4'h0);
        resolve(32'h40, 1'b0, 32'h0, 4'h0);
        #1;
        check("sat_nt1_pv", 32'(prediction_valid), 32'd1);
        check("sat_nt1_ppc", predicted_pc, 32'h20);
        resolve(32'h40, 1'b0, 32'h0, 4'h0);
        #1;
        check("sat_nt2_pv", 32'(prediction_valid), 32'd0);
        check("sat_nt2_ppc", predicted_pc, 32'h44);
        // Raise PHT[0] via another PC (0x44 ^ 0001 -> idx 0) to show BTB[0] survived
        resolve(32'h44, 1'b1, 32'h80, 4'h1);
        #1;
        check("btb_kept_pv", 32'(prediction_valid), 32'd1);
        check("btb_kept_ppc", predicted_pc, 32'h20);
        check("sat_rcnt", 32'(resolve_count), 32'd7);

        // Make PHT[1] and PHT[3] weakly taken for the shift sequence
        resolve(32'h40, 1'b1, 32'h20, 4'h1);
        resolve(32'h40, 1'b1, 32'h20, 4'h3);

        // GHR speculative shift
        fetch_pc = 32'h40; fetch_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("shift%0d_ghr", k), 32'(ghr_out), 32'(shift_exp[k]));
            check($sformatf("shift%0d_pv", k), 32'(prediction_valid), 32'd1);
            step();
        end
        fetch_valid = 1'b0;
        #1;
        check("shift_final_ghr", 32'(ghr_out), 32'h7);

        // Redirect repair with resolve
        pc_redirect = 1'b1; branch_resolved = 1'b1; branch_taken = 1'b0;
        resolved_pc = 32'h40; ghr_history = 4'h1;
        step();
        pc_redirect = 1'b0; branch_resolved = 1'b0;
        #1;
        check("repair_ghr", 32'(ghr_out), 32'h2);
        check("repair_mcnt", 32'(mispredict_count), 32'd1);
        check("repair_rcnt", 32'(resolve_count), 32'd10);

        // Simultaneous jal redirect and speculative shift (hit, PHT[2] not taken)
        fetch_pc = 32'h40; fetch_valid = 1'b1;
        #1;
        check("simul_pv", 32'(prediction_valid), 32'd0);
        check("simul_ppc", predicted_pc, 32'h44);
        pc_redirect = 1'b1; ghr_history = 4'hA;
        step();
        pc_redirect = 1'b0; fetch_valid = 1'b0;
        #1;
        check("simul_ghr", 32'(ghr_out), 32'hA);
        check("simul_mcnt", 32'(mispredict_count), 32'd2);
        check("simul_rcnt", 32'(resolve_count), 32'd10);

        // BTB aliasing: same index, different tag -> miss, no shift
        fetch_pc = 32'h440; fetch_valid = 1'b1;
        #1;
        check("alias_pv", 32'(prediction_valid), 32'd0);
        check("alias_ppc", predicted_pc, 32'h444);
        step();
        fetch_valid = 1'b0;
        #1;
        check("alias_ghr", 32'(ghr_out), 32'hA);

        // Reset mid-training: forced outputs, update discarded
        rst = 1'b1; fetch_pc = 32'h40;
        branch_resolved = 1'b1; branch_taken = 1'b1;
        resolved_pc = 32'h40; branch_addr = 32'h20; ghr_history = 4'h0;
        #1;
        check("rst_force_ghr", 32'(ghr_out), 32'h0);
        check("rst_force_ppc", predicted_pc, 32'h44);
        step();
        rst = 1'b0; branch_resolved = 1'b0; branch_taken = 1'b0;
        #1;
        check("rst2_pv", 32'(prediction_valid), 32'd0);
        check("rst2_ppc", predicted_pc, 32'h44);
        check("rst2_rcnt", 32'(resolve_count), 32'd0);
        check("rst2_mcnt", 32'(mispredict_count), 32'd0);
        check("rst2_ghr", 32'(ghr_out), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
